gyro_frame_sequencer: RTL and testbench
=======================================

// Module: gyro_frame_sequencer
// PURPOSE
//  Run controller for the gyro serializer. Sequences one playback/capture run of N frames
//  (N = 64 << packet_sel), with 3 x 16-bit words per 48-bit frame.
//  - TX side: assembles one upstream sample stream into frames for the serializer's
//    three TX channels, and drives out_start_stop.
//  - RX side: counts returned RX words, drives in_start_stop, marks the final word with last.
//  - Clocked by the serializer's txclk domain.
// PARAMETERS
//  FRAME_CYCLES  48  clocks the serializer needs to shift one frame; sets the underrun timeout
//  TAIL_CYCLES   52  clocks out_start_stop is held after the final TX handshake
// PORTS
//  clock           in   1   serializer txclk; all logic on posedge
//  reset_n         in   1   async active-low reset
//  start           in   1   pulse: begin run (ignored unless IDLE)
//  abort           in   1   pulse: end run immediately; wins over start
//  packet_sel      in   3   frames per run N = 64<<packet_sel (64..8192); latched at start
//  s_data          in   16  upstream sample; word order ch0,ch1,ch2 repeating
//  s_valid         in   1   upstream valid
//  s_ready         out  1   upstream ready
//  tx_data         out  16  ch0 word to serializer
//  tx1_data        out  16  ch1 word to serializer
//  tx2_data        out  16  ch2 word to serializer
//  tx_valid        out  1   frame valid; drives all three serializer channel valids
//  tx_ready        in   1   serializer ready; its three readies are identical, so ch0 ready is used
//  out_start_stop  out  1   serializer out-bound enable
//  in_start_stop   out  1   serializer in-bound enable
//  rx_data_in      in   16  serializer RX word
//  rx_valid_in     in   1   serializer RX valid
//  rx_ready_out    out  1   ready back to serializer
//  m_data          out  16  RX word downstream (= rx_data_in)
//  m_valid         out  1   RX valid downstream
//  m_ready         in   1   downstream ready
//  m_last          out  1   final RX word of run
//  busy            out  1   state != IDLE
//  done            out  1   one-clock pulse at normal run completion
//  frames_sent     out  14  TX frame handshakes this run
//  underrun        out  1   sticky; cleared by start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; all counters 0; assembly/frame regs 0.
//  States:
//   - IDLE: start -> RUN; latch N; clear counters and underrun.
//   - RUN: frames_sent==N on a TX handshake -> DRAIN.
//   - DRAIN: tail count reaches TAIL_CYCLES and rx_cnt==3N -> DONE.
//   - DONE: one clock, done=1 -> IDLE.
//   - abort in any state -> IDLE next clock; frame_full, counters and start_stops cleared;
//     no done pulse.
//  out_start_stop = RUN | (DRAIN & tail<TAIL_CYCLES).
//  in_start_stop = (RUN|DRAIN) & rx_cnt<3N.
//  TX assembly:
//   - 2-bit slot counter (0,1,2,0...); words 0/1 go to assembly regs a0/a1.
//   - Word 2 copies {a0,a1,s_data} to the frame reg and sets frame_full.
//   - tx_valid = frame_full, registered: 1-clock latency from word-2 acceptance.
//   - s_ready = RUN & accepted_frames<N & (slot!=2 | !frame_full | tx_ready).
//   - tx_valid & tx_ready clears frame_full and increments frames_sent.
//   - Simultaneous word-2 accept and TX handshake: frame reg reloads; frame_full stays 1.
//   - Frame data stable while tx_valid & !tx_ready.
//  Underrun:
//   - idle counter resets on each TX handshake.
//   - If it exceeds FRAME_CYCLES while RUN, 0<frames_sent<N and !frame_full -> underrun=1.
//   - The run continues after underrun.
//  RX:
//   - m_data = rx_data_in.
//   - While rx_cnt<3N: m_valid = rx_valid_in and rx_ready_out = m_ready.
//   - Otherwise: m_valid=0 and rx_ready_out=1 (flush/discard).
//   - rx_cnt (15 bits) increments on m_valid & m_ready.
//   - m_last = m_valid & rx_cnt==3N-1.
//  Counter widths hold N=8192 (frames_sent 14b, rx 15b) without wrap.
// TESTING
//  - packet_sel=0, continuous s_valid, tx_ready every 48 clk -> 64 frames, frames_sent=64,
//    out_start_stop low 52 clk after last handshake, no underrun.
//  - Words 0x1111,0x2222,0x3333 -> tx_data/tx1/tx2 = those values, tx_valid 1 clk after third word;
//    hold with tx_ready=0 keeps data stable and s_ready=0 at slot 2.
//  - Loopback-style RX: 192 words with m_ready toggling -> m_last only on 192nd accepted word;
//    done pulses once; extra rx words are discarded with rx_ready_out=1.
//  - Stall s_valid for 100 clk after frame 5 -> underrun=1 (sticky); run still completes with done.
//  - abort mid-frame (slot=1) -> next clk IDLE, both start_stops 0, tx_valid 0, no done;
//    new start runs cleanly from slot 0.
//  - start and abort in the same clock -> stays IDLE. start while RUN -> ignored.
//    reset_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/gyro_frame_sequencer_if.sv
// gyro_frame_sequencer_if: upstream, serializer and downstream streams of the gyro frame sequencer
interface gyro_frame_sequencer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] tx_data;
  logic [15:0] tx1_data;
  logic [15:0] tx2_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        out_start_stop;
  logic        in_start_stop;
  logic [15:0] rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  modport master (
    input  s_data, s_valid, tx_ready, rx_data_in, rx_valid_in, m_ready,
    output s_ready, tx_data, tx1_data, tx2_data, tx_valid, out_start_stop, in_start_stop,
           rx_ready_out, m_data, m_valid, m_last
  );
  modport slave (
    output s_data, s_valid, tx_ready, rx_data_in, rx_valid_in, m_ready,
    input  s_ready, tx_data, tx1_data, tx2_data, tx_valid, out_start_stop, in_start_stop,
           rx_ready_out, m_data, m_valid, m_last
  );
endinterface

// File: rtl/gyro_frame_sequencer.sv
// gyro_frame_sequencer: sequences one TX playback / RX capture run of N three-word frames
module gyro_frame_sequencer #(
  parameter int FRAME_CYCLES = 48,
  parameter int TAIL_CYCLES  = 52
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [2:0]                    packet_sel,
  output logic                          busy,
  output logic                          done,
  output logic [13:0]                   frames_sent,
  output logic                          underrun,
  gyro_frame_sequencer_if.master        io
);
  localparam int TW = $clog2(TAIL_CYCLES + 1);
  localparam int IW = $clog2(FRAME_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [13:0] n_frames, acc_frames;
  logic [14:0] n_words, rx_cnt;
  logic [1:0]  slot;
  logic [15:0] a0, a1;
  logic [47:0] frame;
  logic        frame_full;
  logic [TW-1:0] tail;
  logic [IW-1:0] idle;
  logic start_ok, s_acc, word2, tx_hs, last_hs, tail_end, idle_sat, rx_open, rx_hs;
  assign n_words  = {1'b0, n_frames} + {n_frames, 1'b0};
  assign start_ok = state == IDLE && start && !abort;
  assign tx_hs    = frame_full && io.tx_ready;
  assign last_hs  = state == RUN && tx_hs && frames_sent == n_frames - 14'd1;
  assign tail_end = tail == TW'(TAIL_CYCLES);
  assign idle_sat = idle > IW'(FRAME_CYCLES);
  // slot 2 may only be taken when the frame reg is free or being handed off this clock
  assign io.s_ready = state == RUN && acc_frames < n_frames &&
                      (slot != 2'd2 || !frame_full || io.tx_ready);
  assign s_acc = io.s_valid && io.s_ready;
  assign word2 = s_acc && slot == 2'd2;
  assign io.tx_valid = frame_full;
  assign {io.tx_data, io.tx1_data, io.tx2_data} = frame;
  assign io.out_start_stop = state == RUN || (state == DRAIN && !tail_end);
  assign rx_open = (state == RUN || state == DRAIN) && rx_cnt < n_words;
  assign io.in_start_stop = rx_open;
  assign io.m_data = io.rx_data_in;
  assign io.m_valid = rx_open && io.rx_valid_in;
  // past the final word the serializer is drained by accepting and discarding
  assign io.rx_ready_out = state != IDLE && (rx_open ? io.m_ready : 1'b1);
  assign io.m_last = io.m_valid && rx_cnt == n_words - 15'd1;
  assign rx_hs = io.m_valid && io.m_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = abort ? IDLE :
               state == IDLE  ? (start ? RUN : IDLE) :
               state == RUN   ? (last_hs ? DRAIN : RUN) :
               state == DRAIN ? (tail_end && rx_cnt == n_words ? DONE : DRAIN) :
               IDLE;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      n_frames    <= '0;
      acc_frames  <= '0;
      frames_sent <= '0;
      rx_cnt      <= '0;
      slot        <= '0;
      a0          <= '0;
      a1          <= '0;
      frame       <= '0;
      frame_full  <= 1'b0;
      tail        <= '0;
      idle        <= '0;
      underrun    <= 1'b0;
    end else if (abort || start_ok) begin
      acc_frames  <= '0;
      frames_sent <= '0;
      rx_cnt      <= '0;
      slot        <= '0;
      frame_full  <= 1'b0;
      tail        <= '0;
      idle        <= '0;
      if (start_ok) begin
        n_frames <= 14'd64 << packet_sel;
        underrun <= 1'b0;
      end
    end else begin
      if (s_acc) slot <= slot == 2'd2 ? 2'd0 : slot + 2'd1;
      if (s_acc && slot == 2'd0) a0 <= io.s_data;
      if (s_acc && slot == 2'd1) a1 <= io.s_data;
      if (word2) frame <= {a0, a1, io.s_data};
      if (word2) acc_frames <= acc_frames + 14'd1;
      frame_full <= word2 || (frame_full && !io.tx_ready);
      if (tx_hs) frames_sent <= frames_sent + 14'd1;
      if (rx_hs) rx_cnt <= rx_cnt + 15'd1;
      tail <= state != DRAIN ? '0 : tail_end ? tail : tail + TW'(1);
      idle <= (tx_hs || state != RUN) ? '0 : idle_sat ? idle : idle + IW'(1);
      if (state == RUN && idle_sat && frames_sent != 14'd0 && frames_sent < n_frames && !frame_full)
        underrun <= 1'b1;
    end
endmodule

// File: tb/tb_gyro_frame_sequencer.sv
// tb_gyro_frame_sequencer: control vector table, directed frame/abort/reset corners, and
// randomized runs scored against a count-and-queue model of the run
module tb_gyro_frame_sequencer;
  localparam int FC = 48;
  localparam int TC = 52;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  packet_sel = 3'd0;
  logic        busy, done, underrun;
  logic [13:0] frames_sent;
  int checks = 0;
  int errors = 0;
  gyro_frame_sequencer_if bus();
  gyro_frame_sequencer #(.FRAME_CYCLES(FC), .TAIL_CYCLES(TC)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort), .packet_sel(packet_sel),
    .busy(busy), .done(done), .frames_sent(frames_sent), .underrun(underrun), .io(bus)
  );
  always #5 clock = ~clock;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  typedef struct packed { logic st; logic ab; logic busy; logic oss; logic iss; } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, " busy"}, busy, 0);
    chk({t, " done"}, done, 0);
    chk({t, " frames_sent"}, frames_sent, 0);
    chk({t, " underrun"}, underrun, 0);
    chk({t, " s_ready"}, bus.s_ready, 0);
    chk({t, " tx_valid"}, bus.tx_valid, 0);
    chk({t, " tx_frame"}, {bus.tx_data, bus.tx1_data, bus.tx2_data}, 0);
    chk({t, " out_ss"}, bus.out_start_stop, 0);
    chk({t, " in_ss"}, bus.in_start_stop, 0);
    chk({t, " m_valid"}, bus.m_valid, 0);
    chk({t, " rx_ready_out"}, bus.rx_ready_out, 0);
    chk({t, " m_last"}, bus.m_last, 0);
  endtask

  task automatic put_word(input logic [15:0] w, input logic exp_txv);
    bus.s_valid = 1'b1;
    bus.s_data = w;
    #1;
    chk("put s_ready", bus.s_ready, 1);
    chk("put tx_valid", bus.tx_valid, exp_txv);
    @(negedge clock);
    bus.s_valid = 1'b0;
  endtask

  // mode 0: random traffic; 1: continuous s_valid, tx_ready once every FC clocks;
  // 2: as mode 1 with s_valid withheld for 100 clocks once frame 5 has been sent
  task automatic run(input logic [2:0] psel, input int mode, input int exp_ur);
    int n = 64 << psel;
    int w_acc = 0, hs = 0, rx_acc = 0, tail = 0, phase = 1, cyc = 0, stall = 0;
    bit stalled = 0;
    logic [15:0] words[$];
    logic [47:0] want;
    logic full, exp_sr, exp_mv, rx_open, ths;
    @(negedge clock);
    packet_sel = psel;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    packet_sel = 3'($urandom_range(7));
    while (phase != 0 && cyc < 20000) begin
      if (mode == 0) begin
        bus.s_valid = $urandom_range(3) != 0;
        bus.tx_ready = $urandom_range(1) == 1;
      end else begin
        bus.s_valid = stall == 0;
        bus.tx_ready = (cyc % FC) == FC - 1;
      end
      if (!bus.s_valid || $urandom_range(1) == 1) bus.s_data = 16'($urandom);
      bus.rx_valid_in = $urandom_range(1) == 1;
      bus.rx_data_in = 16'($urandom);
      bus.m_ready = $urandom_range(1) == 1;
      #1;
      full = (w_acc / 3) > hs;
      exp_sr = phase == 1 && w_acc < 3 * n && ((w_acc % 3) != 2 || !full || bus.tx_ready);
      rx_open = (phase == 1 || phase == 2) && rx_acc < 3 * n;
      exp_mv = rx_open && bus.rx_valid_in;
      chk("run s_ready", bus.s_ready, exp_sr);
      chk("run tx_valid", bus.tx_valid, full);
      chk("run frames_sent", frames_sent, 48'(hs));
      chk("run busy", busy, phase != 0);
      chk("run done", done, phase == 3);
      chk("run out_ss", bus.out_start_stop, phase == 1 || (phase == 2 && tail < TC));
      chk("run in_ss", bus.in_start_stop, rx_open);
      chk("run m_valid", bus.m_valid, exp_mv);
      chk("run rx_ready_out", bus.rx_ready_out, phase != 0 && (rx_open ? bus.m_ready : 1'b1));
      chk("run m_last", bus.m_last, exp_mv && rx_acc == 3 * n - 1);
      chk("run m_data", bus.m_data, bus.rx_data_in);
      ths = full && bus.tx_ready;
      if (ths && words.size() >= 3) begin
        want = {words[0], words[1], words[2]};
        chk("run tx_frame", {bus.tx_data, bus.tx1_data, bus.tx2_data}, want);
        repeat (3) void'(words.pop_front());
      end
      if (bus.s_valid && exp_sr) begin
        words.push_back(bus.s_data);
        w_acc++;
      end
      if (phase == 1 && ths && hs + 1 == n) begin
        phase = 2;
        tail = 0;
      end else if (phase == 2) begin
        if (tail == TC && rx_acc == 3 * n) phase = 3;
        else if (tail < TC) tail++;
      end else if (phase == 3) phase = 0;
      if (ths) hs++;
      if (exp_mv && bus.m_ready) rx_acc++;
      if (stall > 0) stall--;
      if (mode == 2 && !stalled && hs == 5) begin
        stall = 100;
        stalled = 1;
      end
      cyc++;
      @(negedge clock);
    end
    bus.s_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.m_ready = 1'b0;
    #1;
    chk("run completed in budget", phase == 0, 1);
    chk("run end frames_sent", frames_sent, 48'(n));
    chk("run end busy", busy, 0);
    if (exp_ur >= 0) chk("run end underrun", underrun, 48'(exp_ur));
  endtask

  initial begin
    tbl = '{5'b11000, 5'b00000, 5'b10111, 5'b10111, 5'b01000,
            5'b01000, 5'b10111, 5'b00111, 5'b11000};
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.tx_ready = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.rx_data_in = '0;
    bus.m_ready = 1'b0;
    #1 reset_n = 1'b0;
    bus.m_ready = 1'b1;
    bus.rx_valid_in = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1 chk_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    bus.m_ready = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      start = tbl[i].st;
      abort = tbl[i].ab;
      @(negedge clock);
      start = 1'b0;
      abort = 1'b0;
      #1;
      chk("vec busy", busy, tbl[i].busy);
      chk("vec out_ss", bus.out_start_stop, tbl[i].oss);
      chk("vec in_ss", bus.in_start_stop, tbl[i].iss);
      chk("vec done", done, 0);
      chk("vec frames_sent", frames_sent, 0);
    end
    @(negedge clock);
    packet_sel = 3'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    put_word(16'h1111, 0);
    put_word(16'h2222, 0);
    put_word(16'h3333, 0);
    #1;
    chk("asm tx_valid", bus.tx_valid, 1);
    chk("asm frame", {bus.tx_data, bus.tx1_data, bus.tx2_data}, 48'h1111_2222_3333);
    put_word(16'h4444, 1);
    put_word(16'h5555, 1);
    bus.s_valid = 1'b1;
    bus.s_data = 16'h6666;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold s_ready", bus.s_ready, 0);
      chk("hold frame", {bus.tx_data, bus.tx1_data, bus.tx2_data}, 48'h1111_2222_3333);
      @(negedge clock);
    end
    bus.tx_ready = 1'b1;
    #1 chk("reload s_ready", bus.s_ready, 1);
    @(negedge clock);
    bus.tx_ready = 1'b0;
    bus.s_valid = 1'b0;
    #1;
    chk("reload tx_valid", bus.tx_valid, 1);
    chk("reload frame", {bus.tx_data, bus.tx1_data, bus.tx2_data}, 48'h4444_5555_6666);
    chk("reload frames_sent", frames_sent, 1);
    put_word(16'h7777, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort out_ss", bus.out_start_stop, 0);
    chk("abort in_ss", bus.in_start_stop, 0);
    chk("abort tx_valid", bus.tx_valid, 0);
    chk("abort frames_sent", frames_sent, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort done", done, 0);
      @(negedge clock);
      #1;
    end
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    put_word(16'h0a1a, 0);
    put_word(16'h0b2b, 0);
    put_word(16'h0c3c, 0);
    #1 chk("restart frame", {bus.tx_data, bus.tx1_data, bus.tx2_data}, 48'h0a1a_0b2b_0c3c);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    run(3'd0, 1, 0);
    run(3'd0, 2, 1);
    run(3'd1, 0, -1);
    run(3'd0, 0, -1);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = 16'hbeef;
    bus.tx_ready = 1'b1;
    bus.rx_valid_in = 1'b1;
    bus.m_ready = 1'b1;
    repeat (12) @(negedge clock);
    #1 chk("arst pre busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("arst");
    @(negedge clock);
    reset_n = 1'b1;
    bus.s_valid = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid_in = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
